// File: rtl/result_packetizer.sv
// Frames one hash result (WORDS_PER_BLOCK FIFO words) as header + payload (+ XOR trailer when
// RESULT_PKT_CHECKSUM_EN is defined) on a valid/ready stream; a 2-entry buffer hides the FIFO read latency.
module result_packetizer #(
  parameter int          WORDS_PER_BLOCK = 96,
  parameter logic [15:0] MAGIC           = 16'hA5C3
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [31:0] read_data,
  output logic        rd_en,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic [15:0] seq_num
);

  localparam int CW = $clog2(WORDS_PER_BLOCK + 1);

`ifdef RESULT_PKT_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} state_t;
`else
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;
`endif

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_buf0;
  logic [31:0]   r_buf1;
  logic [1:0]    r_cnt;
  logic          r_inflight;
  logic [CW-1:0] r_req;
  logic [CW-1:0] r_sent;
  logic [15:0]   r_seq;
`ifdef RESULT_PKT_CHECKSUM_EN
  logic [31:0]   r_csum;
`endif

  logic [31:0]   w_head;
  logic          w_buf_vld;
  logic          w_last_pay;
  logic          w_pop;
  logic          w_pkt_done;
  logic [2:0]    w_occ;

  // The word arriving from the FIFO this cycle is presented directly when the buffer is empty,
  // so the first payload word can follow the header without a bubble.
  assign w_head     = (r_cnt != 2'd0) ? r_buf0 : read_data;
  assign w_buf_vld  = (r_cnt != 2'd0) || r_inflight;
  assign w_last_pay = (r_sent == CW'(WORDS_PER_BLOCK - 1));
  assign w_occ      = {1'b0, r_cnt} + {2'b00, r_inflight};

  always_comb begin
    w_state_nxt = r_state;
    out_valid   = 1'b0;
    out_data    = 32'd0;
    out_last    = 1'b0;
    w_pop       = 1'b0;
    w_pkt_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!fifo_empty) w_state_nxt = HEADER;
      end
      HEADER: begin
        out_valid = 1'b1;
        out_data  = {MAGIC, r_seq};
        if (out_ready) w_state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        out_valid = w_buf_vld;
        out_data  = w_buf_vld ? w_head : 32'd0;
        w_pop     = w_buf_vld && out_ready;
`ifdef RESULT_PKT_CHECKSUM_EN
        if (w_pop && w_last_pay) w_state_nxt = TRAILER;
`else
        out_last   = w_buf_vld && w_last_pay;
        w_pkt_done = w_pop && w_last_pay;
        if (w_pkt_done) w_state_nxt = IDLE;
`endif
      end
`ifdef RESULT_PKT_CHECKSUM_EN
      TRAILER: begin
        out_valid  = 1'b1;
        out_data   = r_csum;
        out_last   = 1'b1;
        w_pkt_done = out_ready;
        if (out_ready) w_state_nxt = IDLE;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  // Room is judged after this cycle's pop so a full-rate stream keeps one read in flight.
  assign rd_en = !rst && !fifo_empty
              && ((r_state == HEADER) || (r_state == PAYLOAD))
              && ((w_occ - {2'b00, w_pop}) < 3'd2)
              && (r_req < CW'(WORDS_PER_BLOCK));

  assign busy    = (r_state != IDLE);
  assign seq_num = r_seq;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state    <= IDLE;
      r_buf0     <= 32'd0;
      r_buf1     <= 32'd0;
      r_cnt      <= 2'd0;
      r_inflight <= 1'b0;
      r_req      <= '0;
      r_sent     <= '0;
      r_seq      <= 16'd0;
`ifdef RESULT_PKT_CHECKSUM_EN
      r_csum     <= 32'd0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= rd_en;
      if (rd_en) r_req <= r_req + CW'(1);
      // Buffer keeps queue order: stored entries first, then the word landing this cycle.
      if (w_pop) begin
        r_buf0 <= (r_cnt == 2'd2) ? r_buf1 : read_data;
      end else begin
        r_buf0 <= w_head;
        r_buf1 <= (r_cnt == 2'd2) ? r_buf1 : read_data;
      end
      r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
      if (w_pop) r_sent <= r_sent + CW'(1);
`ifdef RESULT_PKT_CHECKSUM_EN
      if (r_state == HEADER && out_ready) r_csum <= 32'd0;
      else if (w_pop)                     r_csum <= r_csum ^ w_head;
`endif
      if (w_pkt_done) begin
        r_seq  <= r_seq + 16'd1;
        r_req  <= '0;
        r_sent <= '0;
      end
    end
  end

endmodule

// File: tb/tb_result_packetizer.sv
// Bench for result_packetizer: behavioural FIFO plus packet-level reference model
// (expected stream = header, payload words, optional XOR trailer).
module tb_result_packetizer;

  localparam logic [15:0] MAGIC = 16'hA5C3;
  localparam int          WPB   = 96;
`ifdef RESULT_PKT_CHECKSUM_EN
  localparam bit          CSUM  = 1'b1;
`else
  localparam bit          CSUM  = 1'b0;
`endif
  localparam int          PKT   = 1 + WPB + (CSUM ? 1 : 0);

  logic        clk_in;
  logic        rst;
  logic        fifo_empty;
  logic [31:0] read_data;
  logic        rd_en;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic [15:0] seq_num;

  result_packetizer dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .read_data (read_data),
    .rd_en     (rd_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .seq_num   (seq_num)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int mode   = 0;
  int pidx   = 0;
  int viol_rd, viol_last, viol_stab, n_valid;
  bit          prev_stall;
  logic [31:0] prev_dat;
  logic [15:0] exp_seq;
  int          push_cyc;

  logic [31:0] q[$];      // FIFO contents
  logic [31:0] mq[$];     // words the model has yet to frame
  logic [32:0] exp_q[$];  // {last, data}
  logic [32:0] got[$];
  int          got_cyc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: drive ready, sample at negedge+1, pop the FIFO after the edge if rd_en was seen.
  task automatic cycle();
    bit rd_s;
    case (mode)
      1:       out_ready = ($urandom_range(0, 3) != 0);
      2:       out_ready = (pidx >= 20 && pidx < 25) ? 1'b0 : ((pidx % 2) == 0);
      default: out_ready = 1'b1;
    endcase
    pidx++;
    #1;
    rd_s = rd_en;
    if (rd_en && fifo_empty) viol_rd++;
    if (out_last && !out_valid) viol_last++;
    if (prev_stall && !(out_valid && out_data === prev_dat)) viol_stab++;
    prev_stall = out_valid && !out_ready;
    prev_dat   = out_data;
    if (out_valid) n_valid++;
    if (out_valid && out_ready) begin
      got.push_back({out_last, out_data});
      got_cyc.push_back(cyc);
    end
    @(posedge clk_in);
    #1;
    if (rd_s && q.size() > 0) read_data = q.pop_front();
    fifo_empty = (q.size() == 0);
    cyc++;
    @(negedge clk_in);
  endtask

  task automatic push_word(input logic [31:0] w);
    q.push_back(w);
    mq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic add_pkt(input logic [15:0] s);
    logic [31:0] x;
    logic [31:0] w;
    x = 32'd0;
    exp_q.push_back({1'b0, MAGIC, s});
    for (int i = 0; i < WPB; i++) begin
      w = mq.pop_front();
      x = x ^ w;
      exp_q.push_back({(!CSUM && i == WPB - 1), w});
    end
    if (CSUM) exp_q.push_back({1'b1, x});
  endtask

  task automatic start_test();
    got.delete();
    got_cyc.delete();
    exp_q.delete();
    viol_rd = 0; viol_last = 0; viol_stab = 0; n_valid = 0;
    prev_stall = 0; pidx = 0;
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && got.size() < n; i++) cycle();
    chk({tag, " handshakes"}, got.size(), n);
  endtask

  task automatic cmp_stream(input string tag);
    int n;
    chk({tag, " length"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s word %0d", tag, i), got[i], exp_q[i]);
  endtask

  task automatic end_checks(input string tag);
    chk({tag, " rd_en while empty"}, viol_rd, 0);
    chk({tag, " last without valid"}, viol_last, 0);
    chk({tag, " stall stability"}, viol_stab, 0);
    chk({tag, " seq_num"}, seq_num, exp_seq);
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    chk({tag, " rd_en"}, rd_en, 1'b0);
    chk({tag, " out_valid"}, out_valid, 1'b0);
    chk({tag, " out_last"}, out_last, 1'b0);
    chk({tag, " out_data"}, out_data, 32'd0);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " seq_num"}, seq_num, 16'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fifo_empty = 1'b1; read_data = 32'd0; out_ready = 1'b0;
    exp_seq = 16'd0;
    start_test();
    @(negedge clk_in);
    cycle();
    cycle();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Full-rate packet of 0..95
    start_test();
    mode = 0;
    push_cyc = cyc;
    for (int i = 0; i < WPB; i++) push_word(i);
    add_pkt(exp_seq); exp_seq++;
    run_until(PKT, 400, "basic");
    cmp_stream("basic");
    chk("basic header latency", got_cyc[0], push_cyc + 1);
    chk("basic back-to-back span", got_cyc[got_cyc.size()-1] - got_cyc[0], PKT - 1);
    cycle();
    chk("basic busy after packet", busy, 1'b0);
    end_checks("basic");

    // Toggling ready with a 5-cycle stall
    start_test();
    mode = 2;
    for (int i = 0; i < WPB; i++) push_word(i);
    add_pkt(exp_seq); exp_seq++;
    run_until(PKT, 800, "stall");
    cmp_stream("stall");
    cycle();
    end_checks("stall");

    // Underrun after 40 words, refilled 10 cycles later
    start_test();
    mode = 0;
    for (int i = 0; i < 40; i++) push_word($urandom);
    run_until(41, 200, "underrun first part");
    n_valid = 0;
    repeat (10) cycle();
    chk("underrun gap valid cycles", n_valid, 0);
    for (int i = 0; i < WPB - 40; i++) push_word($urandom);
    add_pkt(exp_seq); exp_seq++;
    run_until(PKT, 400, "underrun");
    cmp_stream("underrun");
    cycle();
    end_checks("underrun");

    // Two packets queued, random backpressure
    start_test();
    mode = 1;
    for (int i = 0; i < 2 * WPB; i++) push_word($urandom);
    add_pkt(exp_seq); exp_seq++;
    add_pkt(exp_seq); exp_seq++;
    run_until(2 * PKT, 2000, "two packets");
    cmp_stream("two packets");
    mode = 0;
    cycle();
    end_checks("two packets");

    // Sequence wrap
    start_test();
    mode = 0;
    force dut.r_seq = 16'hFFFF;
    cycle();
    release dut.r_seq;
    exp_seq = 16'hFFFF;
    chk("wrap preset seq_num", seq_num, 16'hFFFF);
    for (int i = 0; i < 2 * WPB; i++) push_word($urandom);
    add_pkt(exp_seq); exp_seq++;
    add_pkt(exp_seq); exp_seq++;
    run_until(2 * PKT, 1000, "wrap");
    cmp_stream("wrap");
    cycle();
    end_checks("wrap");

    // Reset after payload word 30
    start_test();
    mode = 0;
    for (int i = 0; i < 2 * WPB; i++) push_word($urandom);
    run_until(32, 200, "midreset pre");
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_reset_outputs("midreset");
    start_test();
    mq = q;
    exp_seq = 16'd0;
    add_pkt(exp_seq); exp_seq++;
    run_until(PKT, 400, "midreset");
    cmp_stream("midreset");
    chk("midreset rd_en while empty", viol_rd, 0);
    chk("midreset stall stability", viol_stab, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
